// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit LFSR bit generator and its receive-side checker.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package lfsr_pkg;

  localparam int LFSR_W      = 5;
  localparam int LFSR_PERIOD = 31;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

  // Feedback taps: new top bit = s[TAP_A] ^ s[TAP_B].
  localparam int TAP_A = 0;
  localparam int TAP_B = 2;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // One generator step: shift right, feedback enters at the top.
  // The output bit of a state is bit 0, so bit 4 of the next state is the
  // bit that will be emitted five steps later.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[TAP_A] ^ s[TAP_B], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream bundle between the slicer (master) and the PRBS checker (slave).
// Ports: bit_in/bit_valid/clr_count toward the checker; locked/err_pulse/err_count back.
// Backpressure: none, the checker accepts one bit per bit_valid strobe at any rate.
interface prbs_checker_if #(
  parameter int CNT_W = 16
);

  logic             bit_in;
  logic             bit_valid;
  logic             clr_count;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output bit_in, bit_valid, clr_count,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  bit_in, bit_valid, clr_count,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
// Ports: clk, rst_n (async active-low), inc, clr -> cnt. Latency: cnt updates one edge after inc/clr.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 5-bit LFSR bit stream; flags and counts bit errors.
// Ports: clk, reset (async active-low), bus (slave). Latency: locked/err_pulse/err_count one cycle after sampling edge.
// Backpressure: none; accepts a bit on every bit_valid cycle, back-to-back at full rate.
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic           clk,
  input  logic           reset,
  prbs_checker_if.slave  bus
);

  localparam int FE_W = $clog2(ERR_LIMIT + 1);
  localparam logic [FE_W-1:0] ERR_LIM_V  = FE_W'(ERR_LIMIT);
  localparam logic [4:0]      FRAME_LAST = 5'(LFSR_PERIOD - 1);
  localparam logic [2:0]      FILL_FULL  = 3'(LFSR_W);

  chk_state_t        state, state_next;
  logic [LFSR_W-1:0] w, w_next, w_pred;
  logic [2:0]        fill, fill_next;
  logic [4:0]        frame_cnt, frame_cnt_next;
  logic [FE_W-1:0]   frame_err, frame_err_next, frame_err_inc;
  logic              mism;
  logic              locked_q, err_pulse_q;

  always_comb begin
    state_next     = state;
    w_next         = w;
    fill_next      = fill;
    frame_cnt_next = frame_cnt;
    frame_err_next = frame_err;
    frame_err_inc  = frame_err;
    mism           = 1'b0;
    // The window is oldest-bit-at-0, exactly like the generator state, so one
    // generator step yields the predicted next bit at the top.
    w_pred         = lfsr_next(w);

    if (bus.bit_valid) begin
      unique case (state)
        SEARCH: begin
          w_next    = {bus.bit_in, w[LFSR_W-1:1]};
          fill_next = (fill == FILL_FULL) ? fill : fill + 3'd1;
          // An all-zero window is the LFSR lock-up state and can never be
          // part of a valid stream, so keep shifting until it is non-zero.
          if ((fill_next == FILL_FULL) && (w_next != '0)) begin
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          // Shift the prediction rather than the received bit so one flipped
          // bit does not poison the next five predictions.
          w_next        = w_pred;
          mism          = bus.bit_in ^ w_pred[LFSR_W-1];
          frame_err_inc = frame_err + FE_W'(mism);
          if (frame_err_inc == ERR_LIM_V) begin
            state_next     = SEARCH;
            fill_next      = '0;
            frame_cnt_next = '0;
            frame_err_next = '0;
          end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt_next = '0;
            frame_err_next = '0;
          end else begin
            frame_cnt_next = frame_cnt + 5'd1;
            frame_err_next = frame_err_inc;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      w           <= '0;
      fill        <= '0;
      frame_cnt   <= '0;
      frame_err   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state       <= state_next;
      w           <= w_next;
      fill        <= fill_next;
      frame_cnt   <= frame_cnt_next;
      frame_err   <= frame_err_next;
      locked_q    <= (state_next == LOCKED);
      err_pulse_q <= mism;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;

  sat_counter #(
    .W (CNT_W)
  ) u_err_count (
    .clk   (clk),
    .rst_n (reset),
    .inc   (mism),
    .clr   (bus.clr_count),
    .cnt   (bus.err_count)
  );

endmodule
